// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths, load funct3 encodings and the
// load-queue entry layout used by the writeback stage.
package rv32i_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int REG_ADDRESS = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic [REG_ADDRESS-1:0] rd;
        logic [2:0]             funct3;
        logic [1:0]             byte_off;
    } load_entry_t;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Load data lane select and sign/zero extension, purely combinational.
// Unknown funct3 encodings pass the full word through like lw.
module load_extend
    import rv32i_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_off,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[7:0];
        case (byte_off)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (load_funct3_e'(funct3))
            LB:      data = {{24{lane_byte[7]}}, lane_byte};
            LH:      data = {{16{lane_half[15]}}, lane_half};
            LBU:     data = {24'b0, lane_byte};
            LHU:     data = {16'b0, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: merges ALU results and in-order load responses onto one
// register-file write port, with a load scoreboard and optional WB_FORWARD_EN bypass.
module writeback_unit
    import rv32i_pkg::*;
#(
    parameter int DataWidth  = DATA_WIDTH,
    parameter int RegAddress = REG_ADDRESS,
    parameter int LoadDepth  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [RegAddress-1:0] alu_rd,
    input  logic [DataWidth-1:0]  alu_result,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [RegAddress-1:0] ld_issue_rd,
    input  logic [2:0]            ld_issue_funct3,
    input  logic [1:0]            ld_issue_byte_off,
    input  logic                  dmem_rvalid,
    input  logic [DataWidth-1:0]  dmem_rdata,
    input  logic [RegAddress-1:0] source1,
    input  logic [RegAddress-1:0] source2,
    output logic                  stall,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DataWidth-1:0]  fwd_data,
    output logic                  write_enale,
    output logic [RegAddress-1:0] writedata_add,
    output logic [DataWidth-1:0]  write_data,
    output logic                  ld_resp_orphan
);

    localparam int NumRegs = 1 << RegAddress;
    localparam int PtrW    = (LoadDepth > 1) ? $clog2(LoadDepth) : 1;
    localparam int CntW    = $clog2(LoadDepth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(LoadDepth - 1);

    load_entry_t          queue [LoadDepth];
    logic [PtrW-1:0]      head;
    logic [PtrW-1:0]      tail;
    logic [CntW-1:0]      count;
    logic [NumRegs-1:0]   pending;
    logic                 skid_full;
    logic [RegAddress-1:0] skid_rd;
    logic [DataWidth-1:0] skid_data;
    logic                 wb_is_load;
    load_entry_t          head_entry;
    logic [DataWidth-1:0] load_data;
    logic                 queue_full;
    logic                 queue_empty;
    logic                 issue_fire;
    logic                 resp_fire;
    logic                 alu_fire;

    assign queue_full     = (count == CntW'(LoadDepth));
    assign queue_empty    = (count == '0);
    assign ld_issue_ready = !queue_full && !pending[ld_issue_rd];
    assign alu_ready      = !skid_full;
    assign issue_fire     = ld_issue_valid && ld_issue_ready;
    assign resp_fire      = dmem_rvalid && !queue_empty;
    assign alu_fire       = alu_valid && alu_ready;
    assign head_entry     = queue[head];

    load_extend u_extend (
        .funct3   (head_entry.funct3),
        .byte_off (head_entry.byte_off),
        .rdata    (dmem_rdata),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            queue[tail] <= '{rd: ld_issue_rd, funct3: ld_issue_funct3, byte_off: ld_issue_byte_off};
        end
    end

    // Pending clears on the register-file write edge, so stall covers the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            pending        <= '0;
            ld_resp_orphan <= 1'b0;
        end else begin
            if (issue_fire) begin
                tail <= (tail == LastPtr) ? '0 : tail + 1'b1;
            end
            if (resp_fire) begin
                head <= (head == LastPtr) ? '0 : head + 1'b1;
            end
            if (issue_fire && !resp_fire) begin
                count <= count + 1'b1;
            end else if (!issue_fire && resp_fire) begin
                count <= count - 1'b1;
            end
            if (write_enale && wb_is_load) begin
                pending[writedata_add] <= 1'b0;
            end
            if (issue_fire && ld_issue_rd != '0) begin
                pending[ld_issue_rd] <= 1'b1;
            end
            if (dmem_rvalid && queue_empty) begin
                ld_resp_orphan <= 1'b1;
            end
        end
    end

    // Port priority: load response, then skid entry, then fresh ALU input.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_enale   <= 1'b0;
            writedata_add <= '0;
            write_data    <= '0;
            wb_is_load    <= 1'b0;
            skid_full     <= 1'b0;
            skid_rd       <= '0;
            skid_data     <= '0;
        end else begin
            write_enale <= 1'b0;
            wb_is_load  <= 1'b0;
            if (resp_fire) begin
                if (head_entry.rd != '0) begin
                    write_enale   <= 1'b1;
                    writedata_add <= head_entry.rd;
                    write_data    <= load_data;
                    wb_is_load    <= 1'b1;
                end
                if (alu_fire) begin
                    skid_full <= 1'b1;
                    skid_rd   <= alu_rd;
                    skid_data <= alu_result;
                end
            end else if (skid_full) begin
                skid_full <= 1'b0;
                if (skid_rd != '0) begin
                    write_enale   <= 1'b1;
                    writedata_add <= skid_rd;
                    write_data    <= skid_data;
                end
            end else if (alu_fire && alu_rd != '0) begin
                write_enale   <= 1'b1;
                writedata_add <= alu_rd;
                write_data    <= alu_result;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd1_hit = write_enale && (writedata_add == source1) && (source1 != '0);
    assign fwd2_hit = write_enale && (writedata_add == source2) && (source2 != '0);
    assign fwd_data = write_data;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
    assign fwd_data = '0;
`endif

    assign stall = (pending[source1] && source1 != '0 && !fwd1_hit) ||
                   (pending[source2] && source2 != '0 && !fwd2_hit);

endmodule
